// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and helpers for the sequential radix multiplier family.
package seq_mul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   localparam int MAX_W = 64;
   function automatic int iter_count(int width, int radix);
      return width / radix;
   endfunction
   function automatic int cnt_width(int width, int radix);
      return $clog2(width / radix) < 1 ? 1 : $clog2(width / radix);
   endfunction
   // hi/lo are zero-extended halves of a 2*w-bit product
   function automatic logic ovf_check(logic sm, logic [MAX_W-1:0] hi, logic [MAX_W-1:0] lo, int w);
      logic [MAX_W-1:0] mask;
      mask = (MAX_W'(1) << w) - MAX_W'(1);
      return sm ? hi != (lo[w-1] ? mask : '0) : |hi;
   endfunction
endpackage

// File: rtl/seq_mul_radix_if.sv
// seq_mul_radix_if: start/busy/done handshake and operand/result bus of the multiplier.
interface seq_mul_radix_if #(parameter int WIDTH = 8);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             ovf;
   modport master (output start, signed_mode, src1, src2, input busy, done, res_hi, res_lo, ovf);
   modport slave (input start, signed_mode, src1, src2, output busy, done, res_hi, res_lo, ovf);
endinterface

// File: rtl/seq_mul_step.sv
// seq_mul_step: one shift-and-accumulate iteration retiring RADIX_BITS multiplier bits.
module seq_mul_step #(
   parameter int WIDTH = 8,
   parameter int RADIX_BITS = 2
) (
   input  logic [2*WIDTH-1:0]  acc,
   input  logic [WIDTH-1:0]    mag1,
   input  logic [RADIX_BITS-1:0] chunk,
   output logic [2*WIDTH-1:0]  acc_next
);
   assign acc_next = (acc << RADIX_BITS) + (2*WIDTH)'(mag1) * (2*WIDTH)'(chunk);
endmodule

// File: rtl/seq_mul_radix.sv
// seq_mul_radix: iterative sign-magnitude multiplier, MSB-first over the multiplier,
// RADIX_BITS bits per cycle; result held until the next completed operation.
module seq_mul_radix
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RADIX_BITS = 2
) (
   input logic            clk,
   input logic            rst_n,
   seq_mul_radix_if.slave bus
);
   localparam int ITER = iter_count(WIDTH, RADIX_BITS);
   localparam int CW = cnt_width(WIDTH, RADIX_BITS);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);
   if (WIDTH < 4 || WIDTH > MAX_W || RADIX_BITS < 1 || WIDTH % RADIX_BITS != 0) begin : g_bad_params
      $error("seq_mul_radix: RADIX_BITS must divide WIDTH and WIDTH must be 4..64");
   end
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] acc, acc_next, prod, res;
   logic [WIDTH-1:0] mag1, mag2, abs1, abs2;
   logic neg, sm, ovf, done;
   seq_mul_step #(.WIDTH(WIDTH), .RADIX_BITS(RADIX_BITS)) u_step (
      .acc(acc),
      .mag1(mag1),
      .chunk(mag2[WIDTH-1 -: RADIX_BITS]),
      .acc_next(acc_next)
   );
   always_comb begin
      state_n = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (cnt == LAST ? FIX : RUN) : IDLE;
      abs1 = bus.signed_mode && bus.src1[WIDTH-1] ? -bus.src1 : bus.src1;
      abs2 = bus.signed_mode && bus.src2[WIDTH-1] ? -bus.src2 : bus.src2;
      prod = neg ? -acc : acc;
   end
   // mag2 shifts left each iteration so its top RADIX_BITS are always the current chunk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         mag1 <= '0;
         mag2 <= '0;
         neg <= 1'b0;
         sm <= 1'b0;
         res <= '0;
         ovf <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         done <= state == FIX;
         if (state == IDLE && bus.start) begin
            mag1 <= abs1;
            mag2 <= abs2;
            neg <= bus.signed_mode & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
            sm <= bus.signed_mode;
            acc <= '0;
            cnt <= '0;
         end
         if (state == RUN) begin
            acc <= acc_next;
            mag2 <= mag2 << RADIX_BITS;
            cnt <= cnt + 1'b1;
         end
         if (state == FIX) begin
            res <= prod;
            ovf <= ovf_check(sm, MAX_W'(prod[2*WIDTH-1:WIDTH]), MAX_W'(prod[WIDTH-1:0]), WIDTH);
         end
      end
   end
   assign bus.busy = state != IDLE;
   assign bus.done = done;
   assign bus.res_hi = res[2*WIDTH-1:WIDTH];
   assign bus.res_lo = res[WIDTH-1:0];
   assign bus.ovf = ovf;
endmodule

// File: doc/seq_mul_radix.md
Name: seq_mul_radix

Overview:
- Parametrised iterative multiplier for the ALU datapath; successor to the fixed 8x8, 2-bit-per-cycle multiply unit.
- Consumes RADIX_BITS bits of the second operand per cycle, MSB-first, on WIDTH-bit operands.
- Supports unsigned and two's-complement signed modes.
- Uses an explicit start/busy/done handshake and holds its result until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH. Must be at least 4.
- RADIX_BITS, 2, multiplier bits retired per iteration. Must divide WIDTH; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; latched with start.
- src1  in  WIDTH  multiplicand; latched with start.
- src2  in  WIDTH  multiplier; latched with start.
- busy  out  1  high from the edge after an accepted start until done.
- done  out  1  one-cycle pulse; result valid from this cycle on.
- res_hi  out  WIDTH  upper half of the product.
- res_lo  out  WIDTH  lower half of the product.
- ovf  out  1  product does not fit in WIDTH bits (see Behaviour).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, iteration counter 0, accumulator 0, res_hi/res_lo 0, ovf 0, busy 0, done 0.
- Constant ITER = WIDTH/RADIX_BITS.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - latch mode and the magnitudes |src1|, |src2| (signed mode) or the raw values (unsigned mode);
  - latch neg = signed_mode & (src1[MSB] ^ src2[MSB]);
  - clear accumulator and counter; go to RUN; busy=1.
- RUN, each edge: acc <= (acc << RADIX_BITS) + mag1 * chunk.
  - chunk = magnitude-of-src2 bits selected by the counter, MSB-first.
  - The add is 2*WIDTH wide; carries out of bit 2*WIDTH-1 are discarded.
  - Counter increments. After ITER iterations (edge E_ITER), go to FIX.
- FIX, next edge E_(ITER+1):
  - {res_hi,res_lo} <= neg ? -acc : acc (2*WIDTH two's complement);
  - ovf computed from the new result;
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: start edge to done edge is ITER+1 edges (5 for 8/2).
- Throughput: one operation every ITER+2 cycles.
- Overflow rule:
  - unsigned: ovf = |res_hi.
  - signed: ovf = res_hi != {WIDTH{res_lo[WIDTH-1]}}.
- Magnitude of the most-negative value -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits; no special case.
- start while busy (RUN/FIX): ignored, no side effect. Operand or mode changes during RUN do not affect the result.
- start in the cycle done is high: the state is IDLE, so it is accepted. done and the new busy do not overlap; busy rises at the next edge.
- res_hi/res_lo/ovf hold their value until the next FIX edge. They are not cleared on start.
- Reset mid-operation: immediate return to reset values; no done pulse is generated for the aborted operation.
- Zero operands take full latency; no early termination.

Decomposition:
- Package seq_mul_pkg:
  - state enum {IDLE, RUN, FIX};
  - function for iteration count and counter width, clog2(WIDTH/RADIX_BITS) with a minimum of 1;
  - overflow-check function parametrised on width.
- One natural sub-module: seq_mul_step.
  - Combinational; inputs acc, mag1, chunk; output shifted accumulate.
  - Parametrised on WIDTH and RADIX_BITS; reusable by later MAC variants.

Test Plan:
- WIDTH=8, RADIX=2, unsigned, 0xFF*0xFF -> done 5 edges after start, res_hi=0xFE, res_lo=0x01, ovf=1; busy high for exactly the 5 cycles before done.
- Unsigned 12*10 -> res_hi=0x00, res_lo=0x78, ovf=0. Signed -3*5 (0xFD, 0x05) -> res_hi=0xFF, res_lo=0xF1, ovf=0.
- Signed -128*-128 (0x80, 0x80) -> 0x4000, ovf=1. Signed -128*1 -> 0xFF80, ovf=0.
- start pulsed again mid-RUN with different operands -> ignored; first result unchanged. start asserted in the done cycle -> second op accepted, its done 5 edges later.
- rst_n low after 2 RUN edges -> outputs 0, busy 0, no done. A new start after release completes normally.
- WIDTH=16, RADIX=4, unsigned 0xFFFF*0x0001 -> done after 5 edges, res_hi=0x0000, res_lo=0xFFFF, ovf=0. Signed 0x8000*0x7FFF -> 0xC0008000, ovf=1.
